// File: rtl/pulse_seq_timer.sv
// Request sequencer with built-in hold/cooldown down-counter (IDLE/ARM/HOLD/ACTIVE/RELEASE/COOL).
// Optional feature: define PULSE_SEQ_RETRIGGER_EN to let a new request rise restart the sequence from COOL.
module pulse_seq_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic [CNT_W-1:0] t_on,
  input  logic [CNT_W-1:0] t_off,
  output logic             q,
  output logic             start,
  output logic             active,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_HOLD    = 3'd2,
    S_ACTIVE  = 3'd3,
    S_RELEASE = 3'd4,
    S_COOL    = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic             x_q;
  logic             rise_c;

  assign rise_c = x & ~x_q;
  assign count  = timer;

  // Next-state and timer update
  always_comb begin
    state_d = state;
    timer_d = timer;
    case (state)
      S_IDLE: begin
        timer_d = '0;
        if (rise_c) state_d = S_ARM;
      end
      S_ARM: begin
        timer_d = t_on;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!x)                state_d = S_IDLE;
        else if (timer == '0)  state_d = S_ACTIVE;
        else                   timer_d = timer - CNT_W'(1);
      end
      S_ACTIVE: begin
        if (!x) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        timer_d = t_off;
        state_d = S_COOL;
      end
      S_COOL: begin
`ifdef PULSE_SEQ_RETRIGGER_EN
        if (rise_c)            state_d = S_ARM;
        else if (timer == '0)  state_d = S_IDLE;
        else                   timer_d = timer - CNT_W'(1);
`else
        if (timer == '0)       state_d = S_IDLE;
        else                   timer_d = timer - CNT_W'(1);
`endif
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Registers; flag outputs are registered from the next state so they track the state register exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      timer  <= '0;
      x_q    <= 1'b0;
      q      <= 1'b0;
      start  <= 1'b0;
      active <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      x_q    <= x;
      q      <= (state_d == S_ARM);
      start  <= (state_d == S_RELEASE);
      active <= (state_d == S_ACTIVE);
      busy   <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_seq_timer.sv
// Scoreboard bench for pulse_seq_timer: driver pushes model predictions, monitor compares each cycle.
module tb_pulse_seq_timer;

  localparam int unsigned CNT_W = 8;

  localparam int P_IDLE = 0, P_ARM = 1, P_HOLD = 2, P_ACTIVE = 3, P_RELEASE = 4, P_COOL = 5;

  typedef struct {
    logic             q;
    logic             start;
    logic             active;
    logic             busy;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             x;
  logic [CNT_W-1:0] t_on;
  logic [CNT_W-1:0] t_off;
  logic             q;
  logic             start;
  logic             active;
  logic             busy;
  logic [CNT_W-1:0] count;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  bit   drive_done;

  // reference model state
  int   m_phase;
  int   m_left;
  bit   m_xprev;

  pulse_seq_timer #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .x      (x),
    .t_on   (t_on),
    .t_off  (t_off),
    .q      (q),
    .start  (start),
    .active (active),
    .busy   (busy),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the outputs that follow the next clock edge from the request rules.
  function automatic exp_t model_step(bit r, bit xi, int on, int off);
    exp_t e;
    bit   rise;
    if (r) begin
      m_phase = P_IDLE;
      m_left  = 0;
      m_xprev = 1'b0;
    end else begin
      rise = xi && !m_xprev;
      if (m_phase == P_IDLE) begin
        m_left = 0;
        if (rise) m_phase = P_ARM;
      end else if (m_phase == P_ARM) begin
        m_left  = on;
        m_phase = P_HOLD;
      end else if (m_phase == P_HOLD) begin
        if (!xi)              m_phase = P_IDLE;
        else if (m_left == 0) m_phase = P_ACTIVE;
        else                  m_left  = m_left - 1;
      end else if (m_phase == P_ACTIVE) begin
        if (!xi) m_phase = P_RELEASE;
      end else if (m_phase == P_RELEASE) begin
        m_left  = off;
        m_phase = P_COOL;
      end else begin
`ifdef PULSE_SEQ_RETRIGGER_EN
        if (rise)             m_phase = P_ARM;
        else if (m_left == 0) m_phase = P_IDLE;
        else                  m_left  = m_left - 1;
`else
        if (m_left == 0)      m_phase = P_IDLE;
        else                  m_left  = m_left - 1;
`endif
      end
      m_xprev = xi;
    end
    e.q      = (m_phase == P_ARM);
    e.start  = (m_phase == P_RELEASE);
    e.active = (m_phase == P_ACTIVE);
    e.busy   = (m_phase != P_IDLE);
    e.count  = CNT_W'(m_left);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit xi, input int on, input int off);
    reset = r;
    x     = xi;
    t_on  = CNT_W'(on);
    t_off = CNT_W'(off);
    exp_q.push_back(model_step(r, xi, on, off));
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit r, input bit xi, input int on, input int off);
    for (int i = 0; i < n; i++) cyc(r, xi, on, off);
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction, 1 time unit after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!drive_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty at %0t: got no prediction expected one", $time);
        end
      end else begin
        e = exp_q.pop_front();
        chk1("q", q, e.q);
        chk1("start", start, e.start);
        chk1("active", active, e.active);
        chk1("busy", busy, e.busy);
        n_checks++;
        if (count !== e.count) begin
          n_fail++;
          $display("FAIL count at %0t: got %0d expected %0d", $time, count, e.count);
        end
      end
    end
  end

  // Driver: directed scenarios then randomized traffic
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    drive_done = 1'b0;
    m_phase    = P_IDLE;
    m_left     = 0;
    m_xprev    = 1'b0;

    // reset with request held high, then released: rise seen right after reset
    run(2, 1'b1, 1'b1, 3, 2);
    run(8, 1'b0, 1'b1, 3, 2);
    run(6, 1'b0, 1'b0, 3, 2);

    // nominal: t_on=3, t_off=2, request held 10 cycles
    run(10, 1'b0, 1'b1, 3, 2);
    run(8, 1'b0, 1'b0, 3, 2);

    // request too short: hold aborts
    run(2, 1'b0, 1'b1, 3, 2);
    run(6, 1'b0, 1'b0, 3, 2);

    // zero hold time
    run(5, 1'b0, 1'b1, 0, 2);
    run(6, 1'b0, 1'b0, 0, 2);

    // re-rise during cooldown
    run(8, 1'b0, 1'b1, 1, 5);
    run(3, 1'b0, 1'b0, 1, 5);
    run(2, 1'b0, 1'b1, 1, 5);
    run(12, 1'b0, 1'b0, 1, 5);

    // reset in the middle of hold, then a fresh request
    run(4, 1'b0, 1'b1, 3, 2);
    run(1, 1'b1, 1'b1, 3, 2);
    run(4, 1'b0, 1'b0, 3, 2);
    run(12, 1'b0, 1'b1, 3, 2);
    run(6, 1'b0, 1'b0, 3, 2);

    // random traffic; t_on/t_off churn every cycle to expose mis-timed sampling
    begin
      bit xr;
      xr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) xr = ~xr;
        cyc(($urandom_range(0, 199) == 0), xr,
            int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      end
    end
    run(20, 1'b0, 1'b0, 2, 2);

    drive_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
